tdc_pulse_gen: RTL and testbench
================================

// Module: tdc_pulse_gen
//
// PURPOSE
//   Clocked stimulus source for the TDC differential pulse front end: drives the
//   start/stop edge pair whose separation the front end turns into a pulse.
//   Produces a burst of N start/stop pairs with programmable start-to-stop delay and
//   repetition period, both in clk cycles.
//   Used for TDC self-test and linearity calibration inside the Sigma Delta DAQ.
//   Configured by a valid/ready handshake from the control logic.
//
// PARAMETERS
//   CNT_W   16  width of cfg_delay / cfg_period (cycles)
//   REPS_W  8   width of cfg_reps / pulse_idx
//
// PORTS
//   clk         in   1       system clock, all logic on rising edge
//   reset_n     in   1       asynchronous reset, active low
//   cfg_valid   in   1       burst request; cfg_* fields valid while high
//   cfg_ready   out  1       generator idle, can accept a request
//   cfg_delay   in   CNT_W   cycles from start rise to stop rise (0 allowed)
//   cfg_period  in   CNT_W   cycles from one start rise to the next
//   cfg_reps    in   REPS_W  number of start/stop pairs in the burst
//   abort       in   1       synchronous burst cancel
//   start       out  1       start strobe to TDC front end, 1-cycle high
//   stop        out  1       stop strobe to TDC front end, 1-cycle high
//   busy        out  1       burst in progress
//   done        out  1       1-cycle pulse when a burst completes normally
//   pulse_idx   out  REPS_W  pairs issued so far in the current burst
//
// BEHAVIOUR
// - Reset (async, reset_n=0): state IDLE; start=stop=busy=done=0; pulse_idx=0; cfg_ready=1.
// - All outputs are registered. No combinational path from an input to an output.
// - Handshake: a request is accepted on the edge where cfg_valid and cfg_ready are both 1.
//   Call that edge cycle 0. The cfg_* fields are latched at that edge.
//   cfg_ready=0 from cycle 1 until the burst ends.
// - cfg_reps==0: no strobes are issued. done=1 in cycle 1, cfg_ready stays 1.
// - Effective period P = max(cfg_period, cfg_delay+1). The internal timer is CNT_W+1 bits
//   so that P never wraps.
// - For pair k = 0..reps-1:
//     start=1 in cycle 1+k*P.
//     stop=1 in cycle 1+k*P+cfg_delay.
//     pulse_idx increments in the cycle start is high (it reads k+1).
// - cfg_delay==0: start and stop are high in the same cycle. This is the zero-width case;
//   the front end's stop priority yields no pulse.
// - busy=1 from cycle 1 through the cycle of the last stop, inclusive.
// - done=1 in the cycle after the last stop. In that cycle busy=0 and cfg_ready=1.
// - FSM states:
//     IDLE  --accept, reps>0-->  FIRE
//     FIRE  (start=1)  --delay==0-->  GAP
//     FIRE             --delay>0-->   WAIT_STOP
//     WAIT_STOP  --timer==delay (stop=1)-->  GAP
//     GAP  --timer==P, pairs left-->  FIRE
//     GAP  --last pair's stop done-->  DONE
//     DONE  (done=1)  -->  IDLE
// - abort (any non-IDLE state, sampled at an edge):
//     Next cycle: busy=0, done=0, state IDLE, pulse_idx holds its last value.
//     If start was issued and its stop was not, stop=1 for exactly one cycle. This closes
//     the front end window; start is never reasserted.
//     abort while in IDLE has no effect. abort has priority over timer events in the same cycle.
// - A cfg_valid held high after done starts a new burst. The accepting edge may be the
//   done cycle itself.
// - reset_n asserted mid-burst: outputs go to 0 immediately. No closing stop is emitted;
//   the front end must be cleared by the system reset sequence.
// - pulse_idx clears to 0 on each accepted request.
//
// STRUCTURE
// - Package tdc_pkg:
//     - typedef enum for the FSM states {IDLE, FIRE, WAIT_STOP, GAP, DONE}
//     - default CNT_W / REPS_W localparams
// - Sub-module tdc_gen_timer:
//     - CNT_W+1 bit up-counter with clear
//     - flags delay_hit (timer==cfg_delay) and period_hit (timer==P)
// - The top level holds the FSM, the config latch, the reps counter and the output registers.
//
// TESTING
// - delay=3, period=10, reps=2: start in cycles 1 and 11; stop in 4 and 14; done in 15;
//   pulse_idx ends at 2.
// - delay=0, period=4, reps=3: start and stop coincide in cycles 1, 5 and 9; done in 10.
// - delay=8, period=5, reps=2: P clamps to 9; start in 1 and 10; stop in 9 and 18.
// - reps=0: no strobes; done=1 in cycle 1; cfg_ready never drops.
// - delay=20, reps=4, abort in cycle 6: one stop in cycle 7; no further strobes; no done;
//   pulse_idx=1; cfg_ready=1 in cycle 7.
// - reset_n low in cycle 3 of a burst: all outputs 0 asynchronously; after release a new
//   request behaves as a fresh burst.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared types and default widths for the TDC start/stop pulse generator.
package tdc_pkg;

    localparam int unsigned DEF_CNT_W  = 16;
    localparam int unsigned DEF_REPS_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        FIRE,
        WAIT_STOP,
        GAP,
        DONE
    } state_t;

endpackage

// File: rtl/tdc_gen_timer.sv
// Pair timer: counts cycles relative to the latest start strobe and flags the
// stop offset and the effective repetition period.
module tdc_gen_timer
    import tdc_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_period,
    output logic             delay_hit_c,
    output logic             period_hit_c
);

    localparam int unsigned TW = CNT_W + 1;

    logic [TW-1:0] timer;
    logic [TW-1:0] delay_ext;
    logic [TW-1:0] period_ext;
    logic [TW-1:0] p_eff;

    assign delay_ext  = TW'(cfg_delay);
    assign period_ext = TW'(cfg_period);
    // Effective period never lets the next start overtake the current stop.
    assign p_eff      = (period_ext > delay_ext) ? period_ext : delay_ext + TW'(1);

    // Holds the offset of the upcoming cycle, so clear loads 1 during the start cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else if (clr) begin
            timer <= TW'(1);
        end else if (en) begin
            timer <= timer + TW'(1);
        end
    end

    assign delay_hit_c  = (timer == delay_ext);
    assign period_hit_c = (timer == p_eff);

endmodule

// File: rtl/tdc_pulse_gen.sv
// Burst generator of start/stop strobe pairs for TDC self-test and calibration,
// configured through a valid/ready request.
module tdc_pulse_gen
    import tdc_pkg::*;
#(
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned REPS_W = DEF_REPS_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_delay,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [REPS_W-1:0] cfg_reps,
    input  logic              abort,
    output logic              start,
    output logic              stop,
    output logic              busy,
    output logic              done,
    output logic [REPS_W-1:0] pulse_idx
);

    state_t              state;
    state_t              state_d;
    logic [CNT_W-1:0]    delay_q;
    logic [CNT_W-1:0]    period_q;
    logic [REPS_W-1:0]   left_q;
    logic [REPS_W-1:0]   left_d;
    logic [REPS_W-1:0]   idx_d;
    logic                start_d;
    logic                stop_d;
    logic                busy_d;
    logic                done_d;
    logic                ready_d;
    logic                latch_c;
    logic                tclr_c;
    logic                ten_c;
    logic                stop_pending_c;
    logic                delay_hit_c;
    logic                period_hit_c;

    tdc_gen_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .clr          (tclr_c),
        .en           (ten_c),
        .cfg_delay    (delay_q),
        .cfg_period   (period_q),
        .delay_hit_c  (delay_hit_c),
        .period_hit_c (period_hit_c)
    );

    // A start is out whose stop has not yet been issued.
    assign stop_pending_c = ((state == FIRE) && (delay_q != '0)) || (state == WAIT_STOP);
    assign ten_c = (state == FIRE) || (state == WAIT_STOP) || (state == GAP);

    // Next state and next value of every registered output.
    always_comb begin
        state_d = state;
        start_d = 1'b0;
        stop_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        idx_d   = pulse_idx;
        left_d  = left_q;
        latch_c = 1'b0;
        tclr_c  = 1'b0;

        case (state)
            IDLE, DONE: begin
                state_d = IDLE;
                if (cfg_valid && cfg_ready) begin
                    latch_c = 1'b1;
                    idx_d   = '0;
                    if (cfg_reps == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FIRE;
                        start_d = 1'b1;
                        stop_d  = (cfg_delay == '0);
                        busy_d  = 1'b1;
                        idx_d   = REPS_W'(1);
                        left_d  = cfg_reps - REPS_W'(1);
                        tclr_c  = 1'b1;
                    end
                end
            end
            FIRE, WAIT_STOP, GAP: begin
                if (abort) begin
                    // Close an open front-end window exactly once, never restart.
                    state_d = IDLE;
                    stop_d  = stop_pending_c;
                end else if (stop_pending_c) begin
                    busy_d = 1'b1;
                    if (delay_hit_c) begin
                        stop_d  = 1'b1;
                        state_d = GAP;
                    end else begin
                        state_d = WAIT_STOP;
                    end
                end else if (left_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (period_hit_c) begin
                    state_d = FIRE;
                    start_d = 1'b1;
                    stop_d  = (delay_q == '0);
                    busy_d  = 1'b1;
                    idx_d   = pulse_idx + REPS_W'(1);
                    left_d  = left_q - REPS_W'(1);
                    tclr_c  = 1'b1;
                end else begin
                    state_d = GAP;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE) || (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            start     <= 1'b0;
            stop      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_ready <= 1'b1;
            pulse_idx <= '0;
            left_q    <= '0;
            delay_q   <= '0;
            period_q  <= '0;
        end else begin
            state     <= state_d;
            start     <= start_d;
            stop      <= stop_d;
            busy      <= busy_d;
            done      <= done_d;
            cfg_ready <= ready_d;
            pulse_idx <= idx_d;
            left_q    <= left_d;
            if (latch_c) begin
                delay_q  <= cfg_delay;
                period_q <= cfg_period;
            end
        end
    end

endmodule

// File: tb/tb_tdc_pulse_gen.sv
// Self-checking bench for tdc_pulse_gen: directed burst table, corner sequences,
// and randomized bursts against a cycle-indexed arithmetic model.
module tb_tdc_pulse_gen;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [15:0] cfg_delay = '0;
    logic [15:0] cfg_period = '0;
    logic [7:0]  cfg_reps = '0;
    logic        abort = 1'b0;
    logic        start;
    logic        stop;
    logic        busy;
    logic        done;
    logic [7:0]  pulse_idx;

    int checks = 0;
    int errors = 0;
    int burst_id = 0;

    tdc_pulse_gen dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_delay  (cfg_delay),
        .cfg_period (cfg_period),
        .cfg_reps   (cfg_reps),
        .abort      (abort),
        .start      (start),
        .stop       (stop),
        .busy       (busy),
        .done       (done),
        .pulse_idx  (pulse_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       start;
        logic       stop;
        logic       busy;
        logic       done;
        logic       ready;
        logic [7:0] idx;
    } obs_t;

    typedef struct {
        int d, p, r, a;
        int fs, ls, dc, ns, nst, idx;
        int rdrop;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic int nstarts(int pe, int r, int c);
        int n;
        n = (c - 1) / pe + 1;
        return (n < r) ? n : r;
    endfunction

    // Expected outputs in cycle c of a burst accepted at edge 0 (abort in cycle a, 0 = none).
    function automatic obs_t model(int d, int p, int r, int a, int c);
        int   pe, last, ia;
        obs_t o;
        pe = (p > d) ? p : d + 1;
        o = '0;
        o.ready = 1'b1;
        if (r == 0) begin
            o.done = (c == 1);
            return o;
        end
        last = 1 + (r - 1) * pe + d;
        if (a > 0 && c > a) begin
            ia = nstarts(pe, r, a);
            o.idx  = 8'(ia);
            o.stop = (c == a + 1) && (1 + (ia - 1) * pe + d > a);
            return o;
        end
        o.start = ((c - 1) % pe == 0) && ((c - 1) / pe < r);
        o.stop  = (c - 1 - d >= 0) && ((c - 1 - d) % pe == 0) && ((c - 1 - d) / pe < r);
        o.busy  = (c <= last);
        o.done  = (c == last + 1);
        o.ready = !o.busy;
        o.idx   = 8'(nstarts(pe, r, c));
        return o;
    endfunction

    // Caller is mid-cycle of an idle cycle, which becomes cycle 0.
    task automatic run_burst(input int d, input int p, input int r, input int a,
                             output int fs, output int ls, output int dc,
                             output int ns, output int nst, output int fi, output int rdrop);
        int   pe, win;
        obs_t got, exp;
        burst_id++;
        fs = 0; ls = 0; dc = 0; ns = 0; nst = 0; fi = 0; rdrop = 0;
        abort = 1'b0;
        chk($sformatf("b%0d_ready_c0", burst_id), 32'(cfg_ready), 32'd1);
        cfg_valid  = 1'b1;
        cfg_delay  = 16'(d);
        cfg_period = 16'(p);
        cfg_reps   = 8'(r);
        pe = (p > d) ? p : d + 1;
        if (r == 0)      win = 3;
        else if (a > 0)  win = a + 3;
        else             win = 1 + (r - 1) * pe + d + 3;
        for (int c = 1; c <= win; c++) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            abort = (c == a);
            got = {start, stop, busy, done, cfg_ready, pulse_idx};
            exp = model(d, p, r, a, c);
            chk($sformatf("b%0d_cyc%0d", burst_id, c), 32'(got), 32'(exp));
            if (start) begin ns++; if (fs == 0) fs = c; end
            if (stop)  begin nst++; ls = c; end
            if (done)  dc = c;
            if (!cfg_ready) rdrop = 1;
            fi = int'(pulse_idx);
        end
        abort = 1'b0;
    endtask

    vec_t tbl[7];
    int fs, ls, dc, ns, nst, fi, rdrop;

    initial begin
        tbl[0] = '{3, 10, 2, 0, 1, 14, 15, 2, 2, 2, 1};
        tbl[1] = '{0, 4, 3, 0, 1, 9, 10, 3, 3, 3, 1};
        tbl[2] = '{8, 5, 2, 0, 1, 18, 19, 2, 2, 2, 1};
        tbl[3] = '{5, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        tbl[4] = '{20, 30, 4, 6, 1, 7, 0, 1, 1, 1, 1};
        tbl[5] = '{0, 0, 3, 0, 1, 3, 4, 3, 3, 3, 1};
        tbl[6] = '{1, 1, 2, 0, 1, 4, 5, 2, 2, 2, 1};

        repeat (2) @(negedge clk);
        chk("rst_outputs", 32'({start, stop, busy, done, pulse_idx}), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_burst(tbl[i].d, tbl[i].p, tbl[i].r, tbl[i].a, fs, ls, dc, ns, nst, fi, rdrop);
            chk($sformatf("t%0d_first_start", i), 32'(fs), 32'(tbl[i].fs));
            chk($sformatf("t%0d_last_stop", i), 32'(ls), 32'(tbl[i].ls));
            chk($sformatf("t%0d_done_cyc", i), 32'(dc), 32'(tbl[i].dc));
            chk($sformatf("t%0d_n_start", i), 32'(ns), 32'(tbl[i].ns));
            chk($sformatf("t%0d_n_stop", i), 32'(nst), 32'(tbl[i].nst));
            chk($sformatf("t%0d_idx", i), 32'(fi), 32'(tbl[i].idx));
            chk($sformatf("t%0d_ready_drop", i), 32'(rdrop), 32'(tbl[i].rdrop));
        end

        // cfg_valid held high: second burst accepted on the done cycle.
        cfg_valid = 1'b1; cfg_delay = 16'd2; cfg_period = 16'd3; cfg_reps = 8'd1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 2) chk("b2b_no_restart", 32'(start), 32'd0);
            if (c == 3) chk("b2b_stop", 32'({stop, busy, cfg_ready}), 32'b110);
            if (c == 4) chk("b2b_done", 32'({done, busy, cfg_ready}), 32'b101);
            if (c == 5) begin
                chk("b2b_restart", 32'({start, busy, cfg_ready, done}), 32'b1100);
                chk("b2b_idx", 32'(pulse_idx), 32'd1);
                cfg_valid = 1'b0;
            end
        end
        repeat (6) @(negedge clk);
        chk("b2b_idle", 32'({busy, cfg_ready, pulse_idx}), {22'd0, 2'b01, 8'd1});

        // abort while idle is ignored.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort", 32'({start, stop, busy, done, cfg_ready}), 32'b00001);
        @(negedge clk);

        // reset mid-burst clears outputs at once.
        cfg_valid = 1'b1; cfg_delay = 16'd20; cfg_period = 16'd30; cfg_reps = 8'd4;
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_outputs", 32'({start, stop, busy, done, pulse_idx}), 32'd0);
        chk("rst_mid_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_burst(3, 10, 2, 0, fs, ls, dc, ns, nst, fi, rdrop);
        chk("post_rst_done", 32'(dc), 32'd15);

        for (int i = 0; i < 40; i++) begin
            int d, p, r, a, pe, last;
            d = int'($urandom_range(0, 6));
            p = int'($urandom_range(0, 10));
            r = int'($urandom_range(0, 4));
            a = 0;
            if (r > 0 && $urandom_range(0, 2) == 0) begin
                pe = (p > d) ? p : d + 1;
                last = 1 + (r - 1) * pe + d;
                a = int'($urandom_range(1, 32'(last)));
            end
            run_burst(d, p, r, a, fs, ls, dc, ns, nst, fi, rdrop);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
